// File: rtl/rad_async_fifo_wr_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / LOCK)
//   PKT_CNT_W   : width of the completed-packet counter
//   id_width()  : source-ID width for n requesters (minimum 1 bit)
package rad_async_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  localparam int PKT_CNT_W = 16;

  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rad_async_fifo_wr_arb_if.sv
// Bundle between the write-side producers, the arbiter and the FIFO write port.
//   req_valid/req_last/req_data : producer beats (slice i = [i*DWIDTH +: DWIDTH])
//   req_ready                   : per-producer accept
//   wfull/winc/wdata            : FIFO write port, wdata = {source id, payload}
//   busy/gnt_id/pkt_cnt         : arbiter status
// master = arbiter side, slave = producer/FIFO/observer side.
interface rad_async_fifo_wr_arb_if
  import rad_async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8
);
  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wfull;
  logic                      winc;
  logic [IDW+DWIDTH-1:0]     wdata;
  logic                      busy;
  logic [IDW-1:0]            gnt_id;
  logic [PKT_CNT_W-1:0]      pkt_cnt;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, busy, gnt_id, pkt_cnt
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, busy, gnt_id, pkt_cnt
  );

endinterface

// File: rtl/rad_async_fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr,
// wrapping past N-1 to 0.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   any : at least one request set
//   idx : chosen index (only meaningful when any=1)
module rad_rr_pick
  import rad_async_fifo_arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int             sel;

  // Doubling the vector turns the wrap into a plain lowest-bit search:
  // the upper copy covers indices below ptr, the mask drops them from
  // the lower copy so they lose to anything at or after ptr.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    sel = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) sel = (i >= N) ? (i - N) : i;
    end
    any = |req;
    idx = IW'(sel);
  end

endmodule

// File: rtl/rad_async_fifo_wr_arb.sv
// Packet-granular round-robin arbiter for the write port of an async FIFO.
// A grant is held from the first beat to the accepted last beat, so packets
// never interleave; each beat is tagged with its source id.
//   clk : write-domain clock
//   rst : synchronous, active-high reset
//   bus : master side of rad_async_fifo_wr_arb_if (NUM_REQ/DWIDTH must match)
//
// state    | meaning
// ARB_IDLE | no grant; pick next requester from rr_ptr, no transfers
// ARB_LOCK | grant held for gnt_id until its last beat is written
module rad_async_fifo_wr_arb
  import rad_async_fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DWIDTH  = 8,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  rad_async_fifo_wr_arb_if.master bus
);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic                 pick_any;
  logic [IDW-1:0]       pick_idx;
  logic [DWIDTH-1:0]    gnt_data;
  logic                 gnt_valid;
  logic                 gnt_last;
  logic [NUM_REQ-1:0]   ready_c;
  logic                 winc_c;
  logic                 busy_c;

  rad_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_data  = bus.req_data[int'(gnt_id_q)*DWIDTH +: DWIDTH];
  assign gnt_valid = bus.req_valid[gnt_id_q];
  assign gnt_last  = bus.req_last[gnt_id_q];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    pkt_cnt_d = pkt_cnt_q;
    ready_c   = '0;
    winc_c    = 1'b0;
    busy_c    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_id_d = pick_idx;
          state_d  = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        busy_c            = 1'b1;
        ready_c[gnt_id_q] = ~bus.wfull;
        winc_c            = gnt_valid & ~bus.wfull;
        if (winc_c && gnt_last) begin
          state_d   = ARB_IDLE;
          // explicit compare so non-power-of-2 NUM_REQ wraps correctly
          rr_ptr_d  = (gnt_id_q == IDW'(NUM_REQ-1)) ? '0 : gnt_id_q + 1'b1;
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Strobes are forced low during reset so nothing reaches the FIFO while
  // the registers still hold pre-reset state.
  assign bus.req_ready = rst ? '0 : ready_c;
  assign bus.winc      = rst ? 1'b0 : winc_c;
  assign bus.busy      = rst ? 1'b0 : busy_c;
  assign bus.wdata     = rst ? '0 : {gnt_id_q, gnt_data};
  assign bus.gnt_id    = gnt_id_q;
  assign bus.pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_rad_async_fifo_wr_arb.sv
module tb_rad_async_fifo_wr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rad_async_fifo_wr_arb_if #(.NUM_REQ(4), .DWIDTH(8)) b4 ();
  rad_async_fifo_wr_arb_if #(.NUM_REQ(3), .DWIDTH(8)) b3 ();

  rad_async_fifo_wr_arb #(.NUM_REQ(4), .DWIDTH(8)) u4 (.clk(clk), .rst(rst), .bus(b4));
  rad_async_fifo_wr_arb #(.NUM_REQ(3), .DWIDTH(8)) u3 (.clk(clk), .rst(rst), .bus(b3));

  int total = 0;
  int bad   = 0;

  // per-DUT, per-requester beat queues {last, data}
  logic [8:0] rq [2][4][$];
  // scoreboard of expected wdata {id, data}
  logic [9:0] exp4 [$];
  logic [9:0] exp3 [$];

  logic [3:0] dv [2];
  logic [3:0] dl [2];
  logic [7:0] dd [2][4];
  logic [3:0] pv [2];
  logic [3:0] pl [2];
  logic [7:0] pd [2][4];
  logic [3:0] acc [2];
  logic       prst;
  int         wcount;
  logic [9:0] e4, e3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic put(input int d, input int i, input logic last, input logic [7:0] data);
    rq[d][i].push_back({last, data});
  endtask

  task automatic want(input int d, input logic [1:0] id, input logic [7:0] data);
    if (d == 0) exp4.push_back({id, data});
    else        exp3.push_back({id, data});
  endtask

  // One clock: at negedge retire accepted beats, apply rst/wfull and new
  // heads, then sample acceptance once combinational outputs have settled.
  task automatic cycle(input logic full_v = 1'b0, input logic rst_v = 1'b0);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        if (acc[d][i] && rq[d][i].size() > 0) void'(rq[d][i].pop_front());
    for (int d = 0; d < 2; d++) begin
      pv[d] = dv[d]; pl[d] = dl[d];
      for (int i = 0; i < 4; i++) begin
        pd[d][i] = dd[d][i];
        if (rq[d][i].size() > 0) begin
          dv[d][i] = 1'b1;
          {dl[d][i], dd[d][i]} = rq[d][i][0];
        end else begin
          dv[d][i] = 1'b0; dl[d][i] = 1'b0; dd[d][i] = 8'h00;
        end
        if (pv[d][i] && !acc[d][i] && !prst && !rst_v)
          assert (dv[d][i] && dl[d][i] == pl[d][i] && dd[d][i] == pd[d][i])
            else $error("requester %0d/%0d changed before acceptance", d, i);
      end
    end
    rst   = rst_v;
    prst  = rst_v;
    b4.wfull = full_v;
    b3.wfull = 1'b0;
    b4.req_valid = dv[0];
    b4.req_last  = dl[0];
    b4.req_data  = {dd[0][3], dd[0][2], dd[0][1], dd[0][0]};
    b3.req_valid = dv[1][2:0];
    b3.req_last  = dl[1][2:0];
    b3.req_data  = {dd[1][2], dd[1][1], dd[1][0]};
    #1;
    acc[0] = b4.req_valid & b4.req_ready;
    acc[1] = {1'b0, b3.req_valid & b3.req_ready};
    if (b4.winc === 1'b1) wcount++;
  endtask

  task automatic drain(input string nm, input int budget = 60);
    int n;
    n = 0;
    #2;
    while ((rq[0][0].size() + rq[0][1].size() + rq[0][2].size() + rq[0][3].size() +
            rq[1][0].size() + rq[1][1].size() + rq[1][2].size() +
            exp4.size() + exp3.size()) != 0 && n < budget) begin
      cycle();
      #2;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: drain timeout, got %0d cycles, want < %0d", nm, n, budget);
    end
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    #2;
    if (b4.winc === 1'b1) begin
      total++;
      if (exp4.size() == 0) begin
        bad++;
        $display("FAIL wdata4: got unexpected beat %0h, want none", b4.wdata);
      end else begin
        e4 = exp4.pop_front();
        if (b4.wdata !== e4) begin
          bad++;
          $display("FAIL wdata4: got %0h, want %0h", b4.wdata, e4);
        end
      end
    end
    if (b3.winc === 1'b1) begin
      total++;
      if (exp3.size() == 0) begin
        bad++;
        $display("FAIL wdata3: got unexpected beat %0h, want none", b3.wdata);
      end else begin
        e3 = exp3.pop_front();
        if (b3.wdata !== e3) begin
          bad++;
          $display("FAIL wdata3: got %0h, want %0h", b3.wdata, e3);
        end
      end
    end
  end

  initial begin
    prst = 1'b1;
    wcount = 0;
    for (int d = 0; d < 2; d++) begin
      dv[d] = '0; dl[d] = '0; pv[d] = '0; pl[d] = '0; acc[d] = '0;
      for (int i = 0; i < 4; i++) begin dd[d][i] = '0; pd[d][i] = '0; end
    end
    b4.req_valid = '0; b4.req_last = '0; b4.req_data = '0; b4.wfull = 1'b0;
    b3.req_valid = '0; b3.req_last = '0; b3.req_data = '0; b3.wfull = 1'b0;

    // reset state
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("rst_winc", 32'(b4.winc), 0);
    chk("rst_ready", 32'(b4.req_ready), 0);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_wdata", 32'(b4.wdata), 0);
    cycle();
    chk("rst_gnt", 32'(b4.gnt_id), 0);
    chk("rst_pkt", 32'(b4.pkt_cnt), 0);
    chk("rst_idle_busy", 32'(b4.busy), 0);

    // single requester, 3-beat packet
    put(0, 0, 1'b0, 8'hA1); put(0, 0, 1'b0, 8'hA2); put(0, 0, 1'b1, 8'hA3);
    want(0, 2'd0, 8'hA1); want(0, 2'd0, 8'hA2); want(0, 2'd0, 8'hA3);
    cycle();
    chk("t1_arb_winc", 32'(b4.winc), 0);
    chk("t1_arb_busy", 32'(b4.busy), 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t1_winc", 32'(b4.winc), 1);
      chk("t1_busy", 32'(b4.busy), 1);
    end
    cycle();
    chk("t1_busy_end", 32'(b4.busy), 0);
    chk("t1_pkt", 32'(b4.pkt_cnt), 1);
    drain("t1");

    // fairness: fresh reset so rr_ptr starts at 0, all four requesting
    cycle(1'b0, 1'b1);
    put(0, 0, 1'b1, 8'hE0); put(0, 1, 1'b1, 8'hE1); put(0, 2, 1'b1, 8'hE2);
    put(0, 3, 1'b1, 8'hE3); put(0, 0, 1'b1, 8'hE4); put(0, 1, 1'b1, 8'hE5);
    want(0, 2'd0, 8'hE0); want(0, 2'd1, 8'hE1); want(0, 2'd2, 8'hE2);
    want(0, 2'd3, 8'hE3); want(0, 2'd0, 8'hE4); want(0, 2'd1, 8'hE5);
    wcount = 0;
    for (int k = 0; k < 12; k++) cycle();
    chk("fair_beats_in_12", 32'(wcount), 6);
    drain("fair");
    chk("fair_pkt", 32'(b4.pkt_cnt), 6);

    // backpressure mid-packet on req2, req0 waiting alongside
    put(0, 2, 1'b0, 8'hC0); put(0, 2, 1'b0, 8'hC1);
    put(0, 2, 1'b0, 8'hC2); put(0, 2, 1'b1, 8'hC3);
    put(0, 0, 1'b1, 8'h5A);
    want(0, 2'd2, 8'hC0); want(0, 2'd2, 8'hC1); want(0, 2'd2, 8'hC2);
    want(0, 2'd2, 8'hC3); want(0, 2'd0, 8'h5A);
    cycle(); cycle(); cycle();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0);
      chk("bp_winc", 32'(b4.winc), 0);
      chk("bp_ready", 32'(b4.req_ready), 0);
      chk("bp_gnt", 32'(b4.gnt_id), 2);
    end
    drain("bp");
    chk("bp_pkt", 32'(b4.pkt_cnt), 8);

    // NUM_REQ=3: wrap and skip
    put(1, 1, 1'b1, 8'h11); want(1, 2'd1, 8'h11);
    drain("w3_a");
    chk("w3_gnt_a", 32'(b3.gnt_id), 1);
    put(1, 1, 1'b1, 8'h12); want(1, 2'd1, 8'h12);
    drain("w3_b");
    chk("w3_gnt_b", 32'(b3.gnt_id), 1);
    put(1, 0, 1'b1, 8'h30); put(1, 2, 1'b1, 8'h32);
    want(1, 2'd2, 8'h32); want(1, 2'd0, 8'h30);
    drain("w3_c");
    chk("w3_pkt", 32'(b3.pkt_cnt), 4);

    // reset on beat 2 of a 4-beat packet from req3
    put(0, 3, 1'b0, 8'hD0); put(0, 3, 1'b0, 8'hD1);
    put(0, 3, 1'b0, 8'hD2); put(0, 3, 1'b1, 8'hD3);
    want(0, 2'd3, 8'hD0);
    cycle(); cycle();
    chk("mr_beat1", 32'(b4.winc), 1);
    cycle(1'b0, 1'b1);
    chk("mr_rst_winc", 32'(b4.winc), 0);
    chk("mr_rst_ready", 32'(b4.req_ready), 0);
    rq[0][3].delete();
    cycle();
    chk("mr_busy", 32'(b4.busy), 0);
    chk("mr_winc", 32'(b4.winc), 0);
    chk("mr_pkt", 32'(b4.pkt_cnt), 0);
    put(0, 3, 1'b1, 8'h73); put(0, 0, 1'b1, 8'h70);
    want(0, 2'd0, 8'h70); want(0, 2'd3, 8'h73);
    drain("mr");

    // counter wrap
    force u4.pkt_cnt_q = 16'hFFFF;
    put(0, 1, 1'b1, 8'h99); want(0, 2'd1, 8'h99);
    cycle();
    chk("wrap_pre", 32'(b4.pkt_cnt), 32'hFFFF);
    release u4.pkt_cnt_q;
    drain("wrap");
    chk("wrap_post", 32'(b4.pkt_cnt), 0);

    cycle(); cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
